// File: rtl/tb_ram_sp_hs_if.sv
// rtl/tb_ram_sp_hs_if.sv - request/response bus of the handshaked single-port RAM
interface tb_ram_sp_hs_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_i;
    logic                  we_i;
    logic [DATA_W/8-1:0]   be_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W-1:0]     wdata_i;
    logic                  gnt_o;
    logic                  rvalid_o;
    logic [DATA_W-1:0]     rdata_o;
    logic                  err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/tb_ram_sp_hs.sv
// rtl/tb_ram_sp_hs.sv - single-port word RAM with req/gnt/rvalid handshake and programmable latency
module tb_ram_sp_hs #(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 1,
    parameter int    WR_MODE   = 0,
    parameter string INIT_FILE = ""
) (
    input  logic           clk,
    input  logic           rst,
    tb_ram_sp_hs_if.slave  bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d, pend_q, pend_d;
    logic               err_q, err_d, perr_q, perr_d;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               accept;
    logic               in_range;
    logic [ADDR_W-1:0]  word_idx;
    logic [IDX_W-1:0]   mem_idx;
    logic [DATA_W-1:0]  old_word, merged, resp_word;

    assign bus.gnt_o    = (state_q == IDLE) || (state_q == RESP);
    assign bus.rvalid_o = (state_q == RESP);
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;

    // Nothing is accepted while reset is held, so no write can slip into RAM then.
    assign accept   = bus.req_i & bus.gnt_o & ~rst;
    assign word_idx = bus.addr_i >> OFF_W;
    assign in_range = word_idx < ADDR_W'(DEPTH);
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign old_word = mem[mem_idx];

    always_comb begin
        merged = old_word;
        for (int k = 0; k < BE_W; k++) begin
            if (bus.be_i[k]) merged[8*k +: 8] = bus.wdata_i[8*k +: 8];
        end
    end

    always_comb begin
        resp_word = '0;
        if (!bus.we_i) begin
            resp_word = in_range ? old_word : '0;
        end else if (WR_MODE == 1) begin
            resp_word = in_range ? old_word : '0;
        end else if (WR_MODE == 2) begin
            resp_word = in_range ? merged : '0;
        end else begin
            resp_word = rdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        perr_d  = perr_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    rdata_d = pend_q;
                    err_d   = perr_q;
                end
            end
            default: begin
                if (accept) begin
                    pend_d = resp_word;
                    perr_d = ~in_range;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        rdata_d = resp_word;
                        err_d   = ~in_range;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            pend_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            perr_q  <= perr_d;
        end
    end

    // RAM array carries no reset; a write commits at its acceptance edge.
    always_ff @(posedge clk) begin
        if (accept && bus.we_i && in_range) begin
            for (int k = 0; k < BE_W; k++) begin
                if (bus.be_i[k]) mem[mem_idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
            end
        end
    end
endmodule
